// File: rtl/capture_reg_arbiter.sv
// Round-robin arbiter feeding a single capture register, with per-requester burst locking.
// A granted beat lands in the register one cycle later; consume and refill can overlap each cycle.
module capture_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            lock_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [DATA_W-1:0]             data_out_o,
    output logic [$clog2(NUM_REQ)-1:0]    out_id_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   lastGnt_q, lastGnt_d;
    logic [ID_W-1:0]   outId_q, outId_d;
    logic [DATA_W-1:0] dataOut_q, dataOut_d;
    logic              outValid_q, outValid_d;

    logic [NUM_REQ-1:0] rrGnt;
    logic               rrHit;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    grantIdx;
    logic [DATA_W-1:0]  grantData;
    logic               slotFree;
    logic               transfer;

    // Circular successor of base by off positions; off never exceeds NUM_REQ.
    function automatic logic [ID_W-1:0] wrapIdx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    assign slotFree = !outValid_q || out_ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            lastGnt_q <= LAST_IDX;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lastGnt_q <= lastGnt_d;
        end
    end

    // Scan starts just past the last winner, so the previous winner gets lowest priority.
    always_comb begin
        rrGnt = '0;
        rrHit = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!rrHit && req_i[wrapIdx(lastGnt_q, off)]) begin
                rrGnt[wrapIdx(lastGnt_q, off)] = 1'b1;
                rrHit = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (!reset && slotFree) begin
            if (state_q == LOCKED) begin
                gnt[owner_q] = req_i[owner_q];
            end else begin
                gnt = rrGnt;
            end
        end
    end

    always_comb begin
        grantIdx  = '0;
        grantData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                grantIdx  = ID_W'(i);
                grantData = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign transfer = |(gnt & req_i);

    // A lock is only taken on a beat granted from IDLE and only dropped by an unlocked owner beat.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lastGnt_d = lastGnt_q;
        if (transfer) begin
            lastGnt_d = grantIdx;
            case (state_q)
                IDLE: begin
                    if (lock_i[grantIdx]) begin
                        state_d = LOCKED;
                        owner_d = grantIdx;
                    end
                end
                LOCKED: begin
                    if (!lock_i[owner_q]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dataOut_d  = dataOut_q;
        outId_d    = outId_q;
        outValid_d = outValid_q;
        if (transfer) begin
            dataOut_d  = grantData;
            outId_d    = grantIdx;
            outValid_d = 1'b1;
        end else if (out_ready_i) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOut_q  <= '0;
            outId_q    <= '0;
            outValid_q <= 1'b0;
        end else begin
            dataOut_q  <= dataOut_d;
            outId_q    <= outId_d;
            outValid_q <= outValid_d;
        end
    end

    assign gnt_o       = gnt;
    assign data_out_o  = dataOut_q;
    assign out_id_o    = outId_q;
    assign out_valid_o = outValid_q;

    property p_gntOneHot;
        @(posedge clk) disable iff (reset) $onehot0(gnt);
    endproperty
    a_gntOneHot: assert property (p_gntOneHot);

    property p_noGntWhenBusy;
        @(posedge clk) disable iff (reset) !slotFree |-> (gnt == '0);
    endproperty
    a_noGntWhenBusy: assert property (p_noGntWhenBusy);

endmodule

// File: tb/tb_capture_reg_arbiter.sv
// Self-checking bench for capture_reg_arbiter: directed vector table, burst/reset sequences,
// and a long random run against a queue-based reference model of the arbitration rules.
module tb_capture_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   lock = '0;
    logic [N*W-1:0] reqData = '0;
    logic           outReady = 1'b0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   dataOut;
    logic [IW-1:0]  outId;
    logic           outValid;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int           mLast;
    int           mOwner;
    int           mId;
    bit           mLocked;
    bit           mValid;
    logic [W-1:0] mData;
    logic [N-1:0] mGnt;
    bit           mLockedBefore;

    logic [N-1:0]  gntSeen;
    logic          preValid;
    logic [W-1:0]  preData;
    logic [IW-1:0] preId;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        bit           rst;
        logic [N-1:0] req;
        logic [N-1:0] lock;
        bit           rdy;
        logic [N-1:0] expGnt;
        bit           expValid;
        logic [IW-1:0] expId;
        logic [W-1:0] expData;
    } vec_t;
    vec_t vecs[13];

    localparam logic [N*W-1:0] D0 = {8'h13, 8'h12, 8'h11, 8'h10};

    capture_reg_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .lock_i     (lock),
        .req_data_i (reqData),
        .gnt_o      (gnt),
        .data_out_o (dataOut),
        .out_id_o   (outId),
        .out_valid_o(outValid),
        .out_ready_i(outReady)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] modelGrant(input bit r, input logic [N-1:0] rq, input bit rdy);
        if (r) return '0;
        if (mValid && !rdy) return '0;
        if (mLocked) return rq[mOwner] ? (N'(1) << mOwner) : '0;
        for (int k = 1; k <= N; k++) begin
            if (rq[(mLast + k) % N]) return N'(1) << ((mLast + k) % N);
        end
        return '0;
    endfunction

    function automatic int lowestIdx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Drive one cycle, sample pre-edge (gnt, current register), advance the model across the edge.
    task automatic applyStimulus(input bit r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                                 input bit rdy, input logic [N*W-1:0] data);
        int g;
        @(negedge clk);
        reset    = r;
        req      = rq;
        lock     = lk;
        outReady = rdy;
        reqData  = data;
        if (r) begin
            mValid  = 1'b0;
            mData   = '0;
            mId     = 0;
            mLast   = N - 1;
            mLocked = 1'b0;
            sb.delete();
        end
        #1;
        gntSeen  = gnt;
        preValid = outValid;
        preData  = dataOut;
        preId    = outId;
        mGnt     = modelGrant(r, rq, rdy);
        mLockedBefore = mLocked;
        if (!r && preValid && rdy) begin
            if (sb.size() == 0) begin
                checkOutput("sb_spurious_beat", 32'(1), 32'(0));
            end else begin
                beat_t b;
                b = sb.pop_front();
                checkOutput("sb_beat", 32'({preId, preData}), 32'({b.id, b.data}));
            end
        end
        if (!r && ((gntSeen & rq) != '0)) begin
            g = lowestIdx(gntSeen & rq);
            sb.push_back({IW'(g), data[g*W +: W]});
        end
        @(posedge clk);
        if (!r && mGnt != '0) begin
            g      = lowestIdx(mGnt);
            mData  = data[g*W +: W];
            mId    = g;
            mValid = 1'b1;
            mLast  = g;
            if (mLocked) begin
                if (!lk[mOwner]) mLocked = 1'b0;
            end else if (lk[g]) begin
                mLocked = 1'b1;
                mOwner  = g;
            end
        end else if (!r && rdy) begin
            mValid = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [N-1:0] pending;
        logic [N-1:0] granted;
        int           waitCnt[N];
        int           g;
        bit           r;
        logic [N-1:0] lk;
        bit           rdy;

        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        vecs[6]  = '{1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
        vecs[7]  = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h10};
        vecs[8]  = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
        vecs[9]  = '{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
        vecs[10] = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h12};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 8'h12};

        $display("[TB] directed vector table");
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].req, vecs[v].lock, vecs[v].rdy, D0);
            checkOutput($sformatf("vec%0d_gnt", v), 32'(gntSeen), 32'(vecs[v].expGnt));
            checkOutput($sformatf("vec%0d_valid", v), 32'(outValid), 32'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d_id", v), 32'(outId), 32'(vecs[v].expId));
            checkOutput($sformatf("vec%0d_data", v), 32'(dataOut), 32'(vecs[v].expData));
        end

        $display("[TB] locked burst from requester 1");
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b1, D0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, D0);
        checkOutput("burst_pre_id", 32'(outId), 32'(0));
        applyStimulus(1'b0, 4'b1111, 4'b0010, 1'b1, D0);
        checkOutput("burst_b1_gnt", 32'(gntSeen), 32'(4'b0010));
        checkOutput("burst_b1_id", 32'(outId), 32'(1));
        applyStimulus(1'b0, 4'b1111, 4'b1110, 1'b1, D0);
        checkOutput("burst_b2_gnt", 32'(gntSeen), 32'(4'b0010));
        checkOutput("burst_b2_id", 32'(outId), 32'(1));
        applyStimulus(1'b0, 4'b1111, 4'b1101, 1'b1, D0);
        checkOutput("burst_b3_gnt", 32'(gntSeen), 32'(4'b0010));
        checkOutput("burst_b3_id", 32'(outId), 32'(1));
        checkOutput("burst_b3_data", 32'(dataOut), 32'(8'h11));
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, D0);
        checkOutput("burst_after_gnt", 32'(gntSeen), 32'(4'b0100));
        checkOutput("burst_after_id", 32'(outId), 32'(2));
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, D0);
        checkOutput("burst_unlocked_gnt", 32'(gntSeen), 32'(4'b1000));

        $display("[TB] locked owner drops request");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, D0);
        applyStimulus(1'b0, 4'b1000, 4'b1000, 1'b1, D0);
        checkOutput("drop_lock_gnt", 32'(gntSeen), 32'(4'b1000));
        checkOutput("drop_lock_id", 32'(outId), 32'(3));
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1, D0);
        checkOutput("drop_wait1_gnt", 32'(gntSeen), 32'(4'b0000));
        checkOutput("drop_wait1_valid", 32'(outValid), 32'(0));
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1, D0);
        checkOutput("drop_wait2_gnt", 32'(gntSeen), 32'(4'b0000));
        applyStimulus(1'b0, 4'b1001, 4'b0000, 1'b1, D0);
        checkOutput("drop_return_gnt", 32'(gntSeen), 32'(4'b1000));
        checkOutput("drop_return_id", 32'(outId), 32'(3));
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1, D0);
        checkOutput("drop_released_gnt", 32'(gntSeen), 32'(4'b0001));

        $display("[TB] reset during locked burst");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, D0);
        applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0, D0);
        checkOutput("rst_burst_valid", 32'(outValid), 32'(1));
        checkOutput("rst_burst_data", 32'(dataOut), 32'(8'h12));
        applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0, D0);
        checkOutput("rst_async_valid", 32'(preValid), 32'(0));
        checkOutput("rst_async_data", 32'(preData), 32'(0));
        checkOutput("rst_gnt", 32'(gntSeen), 32'(0));
        applyStimulus(1'b0, 4'b1010, 4'b0000, 1'b1, D0);
        checkOutput("rst_restart_gnt", 32'(gntSeen), 32'(4'b0010));
        checkOutput("rst_restart_id", 32'(outId), 32'(1));
        checkOutput("rst_restart_data", 32'(dataOut), 32'(8'h11));

        $display("[TB] random run");
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, D0);
        pending = '0;
        for (int i = 0; i < N; i++) waitCnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            pending = pending | (N'($urandom) & N'($urandom));
            lk  = N'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 1999) == 0);
            applyStimulus(r, pending, lk, rdy, (N*W)'($urandom));
            checkOutput("rand_gnt", 32'(gntSeen), 32'(mGnt));
            checkOutput("rand_onehot", 32'($countones(gntSeen) <= 1), 32'(1));
            checkOutput("rand_valid", 32'(outValid), 32'(mValid));
            checkOutput("rand_id", 32'(outId), 32'(mId));
            checkOutput("rand_data", 32'(dataOut), 32'(mData));
            granted = gntSeen & pending;
            if (r) begin
                for (int i = 0; i < N; i++) waitCnt[i] = 0;
            end else if (granted != '0) begin
                g = lowestIdx(granted);
                checkOutput("rand_starve", 32'(waitCnt[g] <= N), 32'(1));
                for (int i = 0; i < N; i++) begin
                    if (i != g && pending[i] && !mLockedBefore) waitCnt[i]++;
                end
                waitCnt[g] = 0;
            end
            pending = pending & ~granted;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
